lcd_cmd_sequencer: RTL and testbench

- Upstream command feeder for LCD_CTRL.
- Accepts 4-bit image commands from a host push interface and buffers them in a small FIFO.
- Issues one command at a time on LCD_CTRL's cmd/cmd_valid, honouring LCD_CTRL's busy handshake.
- Stops issuing after LCD_CTRL reports done.
- Filters illegal opcodes and exposes progress counters.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_cmd_fifo.sv | 71 +++++++
 rtl/lcd_cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command feeder: opcode map, FSM encoding
// and the legality filter used on the host push path.
package lcd_pkg;

   localparam int CMD_W = 4;

   localparam logic [3:0] CMD_WRITE    = 4'd0;
   localparam logic [3:0] CMD_SHIFT_U  = 4'd1;
   localparam logic [3:0] CMD_SHIFT_D  = 4'd2;
   localparam logic [3:0] CMD_SHIFT_L  = 4'd3;
   localparam logic [3:0] CMD_SHIFT_R  = 4'd4;
   localparam logic [3:0] CMD_MAX      = 4'd5;
   localparam logic [3:0] CMD_MIN      = 4'd6;
   localparam logic [3:0] CMD_AVERAGE  = 4'd7;
   localparam logic [3:0] CMD_CCW      = 4'd8;
   localparam logic [3:0] CMD_CW       = 4'd9;
   localparam logic [3:0] CMD_MIRROR_X = 4'd10;
   localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
   localparam logic [3:0] CMD_LAST_LEGAL = 4'd11;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ISSUE = 3'd1;
   localparam state_t ST_ACK   = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   function automatic logic cmd_is_legal(input logic [CMD_W-1:0] c);
      return (c <= CMD_LAST_LEGAL);
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// DEPTH-entry register FIFO for 4-bit commands; full/empty derive from the
// occupancy count so the pointers can wrap freely.
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] wr_data,
   output logic [CMD_W-1:0] rd_data,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [CMD_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             do_push_s;
   logic             do_pop_s;

   // A push into a full FIFO is only taken when a pop frees the slot.
   always_comb begin
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

   // Command storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign level   = level_r;
   assign full    = (level_r == FULL_LVL);
   assign empty   = (level_r == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Feeds buffered host commands to LCD_CTRL one at a time, pacing each issue
// on the busy handshake and halting once done is reported.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int AW          = 3,
   parameter int ACK_TIMEOUT = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0]       in_cmd,
   output logic             in_ready,
   output logic [3:0]       cmd,
   output logic             cmd_valid,
   input  logic             busy,
   input  logic             done,
   input  logic             flush,
   output logic             seq_done,
   output logic [AW:0]      fifo_level,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   state_t           state_r;
   logic [3:0]       cmd_r;
   logic             cmd_valid_r;
   logic             seq_done_r;
   logic [CNT_W-1:0] issued_r;
   logic [CNT_W-1:0] drop_r;
   logic [TW-1:0]    ack_tmr_r;

   logic [3:0]       head_s;
   logic [AW:0]      level_s;
   logic             full_s;
   logic             empty_s;
   logic             accept_s;
   logic             push_s;
   logic             drop_s;
   logic             pop_s;

   // Host-side filter and the IDLE pop decision; flush and done both veto.
   always_comb begin
      accept_s = in_valid && !full_s && !flush;
      push_s   = accept_s && cmd_is_legal(in_cmd);
      drop_s   = accept_s && !cmd_is_legal(in_cmd);
      pop_s    = (state_r == ST_IDLE) && !empty_s && !busy && !seq_done_r && !done && !flush;
   end

   lcd_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (in_cmd),
      .rd_data (head_s),
      .level   (level_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   // Issue FSM: the timer counts cycles since the strobe, ISSUE being the first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         cmd_r       <= 4'd0;
         cmd_valid_r <= 1'b0;
         seq_done_r  <= 1'b0;
         ack_tmr_r   <= '0;
      end else if (flush) begin
         state_r     <= ST_IDLE;
         cmd_valid_r <= 1'b0;
         seq_done_r  <= 1'b0;
         ack_tmr_r   <= '0;
      end else if (done) begin
         state_r     <= ST_DONE;
         cmd_valid_r <= 1'b0;
         seq_done_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  cmd_r       <= head_s;
                  cmd_valid_r <= 1'b1;
                  state_r     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cmd_valid_r <= 1'b0;
               ack_tmr_r   <= TW'(1);
               state_r     <= ST_ACK;
            end
            ST_ACK: begin
               if (busy || (ack_tmr_r == TW'(ACK_TIMEOUT - 1))) begin
                  state_r <= ST_WAIT;
               end else begin
                  ack_tmr_r <= ack_tmr_r + 1'b1;
               end
            end
            ST_WAIT: begin
               if (!busy) state_r <= ST_IDLE;
            end
            ST_DONE: begin
               state_r <= ST_DONE;
            end
            default: begin
               state_r     <= ST_IDLE;
               cmd_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Saturating progress counters; flush leaves them alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issued_r <= '0;
         drop_r   <= '0;
      end else begin
         if (cmd_valid_r && (issued_r != '1)) issued_r <= issued_r + 1'b1;
         if (drop_s && (drop_r != '1))        drop_r   <= drop_r + 1'b1;
      end
   end

   assign in_ready   = !full_s;
   assign cmd        = cmd_r;
   assign cmd_valid  = cmd_valid_r;
   assign seq_done   = seq_done_r;
   assign fifo_level = level_s;
   assign issued_cnt = issued_r;
   assign drop_cnt   = drop_r;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: directed scenarios plus random traffic, checked
// every cycle against a queue-and-timestamp model of the issue protocol.
module tb_lcd_cmd_sequencer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int ACK_T = 4;
   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [3:0]       in_cmd = 4'd0;
   logic             in_ready;
   logic [3:0]       cmd;
   logic             cmd_valid;
   logic             busy = 1'b0;
   logic             done = 1'b0;
   logic             flush = 1'b0;
   logic             seq_done;
   logic [AW:0]      fifo_level;
   logic [CNT_W-1:0] issued_cnt;
   logic [CNT_W-1:0] drop_cnt;

   lcd_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(ACK_T), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_cmd(in_cmd), .in_ready(in_ready),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done), .flush(flush),
      .seq_done(seq_done), .fifo_level(fifo_level), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Behavioural model: queue contents plus protocol timestamps.
   int m_q[$];
   int m_cmd, m_valid, m_done, m_iss, m_drop;
   int ph;          // 0 free, 1 awaiting ack, 2 awaiting busy release
   int strobe_at, ack_at, free_at;

   int log_cmd[$];
   int log_cyc[$];
   int bmode = 0;   // 0 forced, 1 responder, 2 random
   int bforce = 0;
   int brem = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cmd = 0; m_valid = 0; m_done = 0; m_iss = 0; m_drop = 0;
      ph = 0; strobe_at = -1; ack_at = -1; free_at = -1;
   endtask

   task automatic model_step();
      int k;
      int pre;
      k = cyc;
      pre = m_q.size();
      if (m_valid != 0 && m_iss < MAXC) m_iss++;
      if (flush) begin
         m_q.delete();
         m_done = 0; m_valid = 0; ph = 0; free_at = k;
      end else begin
         if (ph == 1 && k > strobe_at && (busy || (k - strobe_at) == ACK_T - 1)) begin
            ph = 2; ack_at = k;
         end else if (ph == 2 && k > ack_at && !busy) begin
            ph = 0; free_at = k;
         end
         m_valid = 0;
         if (done) begin
            m_done = 1;
         end else if (m_done == 0 && ph == 0 && k > free_at && pre > 0 && !busy) begin
            m_cmd = m_q.pop_front();
            m_valid = 1; ph = 1; strobe_at = k + 1;
         end
         if (in_valid && pre < DEPTH) begin
            if (in_cmd <= 4'd11) m_q.push_back(int'(in_cmd));
            else if (m_drop < MAXC) m_drop++;
         end
      end
   endtask

   // One clock: model advance, DUT edge, per-cycle compare, busy update.
   task automatic tick();
      if (reset) model_step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (reset) begin
         chk("cmd_valid", int'(cmd_valid), m_valid);
         chk("cmd", int'(cmd), m_cmd);
         chk("seq_done", int'(seq_done), m_done);
         chk("fifo_level", int'(fifo_level), m_q.size());
         chk("in_ready", int'(in_ready), (m_q.size() < DEPTH) ? 1 : 0);
         chk("issued_cnt", int'(issued_cnt), m_iss);
         chk("drop_cnt", int'(drop_cnt), m_drop);
         if (cmd_valid) begin
            log_cmd.push_back(int'(cmd));
            log_cyc.push_back(cyc);
         end
      end
      if (bmode == 1) begin
         if (cmd_valid) brem = 2;
         if (brem > 0) begin busy = 1'b1; brem--; end
         else busy = 1'b0;
      end else if (bmode == 2) begin
         busy = ($urandom_range(0, 2) == 0);
      end else begin
         busy = (bforce != 0);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0; in_cmd = 4'd0; done = 1'b0; flush = 1'b0; brem = 0;
      reset = 1'b0;
      model_reset();
      log_cmd.delete(); log_cyc.delete();
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic push1(input int c);
      in_valid = 1'b1; in_cmd = 4'(c);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_log(input string nm, input int n, input int bound);
      int i;
      i = 0;
      while (log_cmd.size() < n && i < bound) begin tick(); i++; end
      chk(nm, log_cmd.size(), n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int codes[9] = '{3, 11, 0, 7, 2, 10, 5, 8, 1};

   initial begin
      // Reset values visible right after release
      do_reset();
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_cmd_valid", int'(cmd_valid), 0);
      chk("rst_issued", int'(issued_cnt), 0);

      // Three commands, busy pulses 2 cycles per issue, then done
      bmode = 1;
      push1(1); push1(9); push1(0);
      wait_log("t1_issues", 3, 60);
      if (log_cmd.size() >= 3) begin
         chk("t1_cmd0", log_cmd[0], 1);
         chk("t1_cmd1", log_cmd[1], 9);
         chk("t1_cmd2", log_cmd[2], 0);
      end
      idle(6);
      chk("t1_issued", int'(issued_cnt), 3);
      done = 1'b1; tick(); done = 1'b0; tick();
      chk("t1_seq_done", int'(seq_done), 1);
      chk("t1_level", int'(fifo_level), 0);

      // Illegal opcodes are dropped
      do_reset();
      push1(12); push1(15); push1(5);
      wait_log("t2_issue", 1, 40);
      if (log_cmd.size() >= 1) chk("t2_cmd", log_cmd[0], 5);
      idle(8);
      chk("t2_drop", int'(drop_cnt), 2);
      chk("t2_issued", int'(issued_cnt), 1);

      // Fill to full with busy held, ninth push ignored, then drain in order
      bmode = 0; bforce = 1; busy = 1'b1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_cmd = 4'(codes[i]);
         tick();
         if (i == 7) begin
            chk("t3_full_level", int'(fifo_level), 8);
            chk("t3_in_ready", int'(in_ready), 0);
         end
      end
      in_valid = 1'b0;
      chk("t3_level_after9", int'(fifo_level), 8);
      bmode = 1;
      wait_log("t3_drain", 8, 200);
      for (int i = 0; i < 8; i++)
         if (i < log_cmd.size()) chk("t3_order", log_cmd[i], codes[i]);

      // busy never rises: issues spaced by the ack timeout
      bmode = 0; bforce = 0; busy = 1'b0;
      do_reset();
      push1(4); push1(6); push1(8);
      wait_log("t4_issues", 3, 60);
      if (log_cyc.size() >= 3) begin
         chk("t4_gap0", log_cyc[1] - log_cyc[0], ACK_T + 2);
         chk("t4_gap1", log_cyc[2] - log_cyc[1], ACK_T + 2);
      end

      // done with three queued, then flush
      bmode = 1;
      do_reset();
      push1(6);
      wait_log("t5_first", 1, 30);
      idle(8);
      bmode = 0; bforce = 1; busy = 1'b1;
      push1(1); push1(2); push1(3);
      done = 1'b1; tick(); done = 1'b0;
      bforce = 0;
      idle(10);
      chk("t5_no_issue", log_cmd.size(), 1);
      chk("t5_level", int'(fifo_level), 3);
      chk("t5_seq_done", int'(seq_done), 1);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t5_flush_level", int'(fifo_level), 0);
      chk("t5_flush_done", int'(seq_done), 0);
      chk("t5_issued_kept", int'(issued_cnt), 1);
      idle(4);
      chk("t5_still_one", log_cmd.size(), 1);

      // Async reset during ACK
      do_reset();
      push1(2); push1(9);
      wait_log("t6_issue", 1, 30);
      tick();
      reset = 1'b0;
      #1;
      chk("t6_cmd_valid", int'(cmd_valid), 0);
      chk("t6_cmd", int'(cmd), 0);
      chk("t6_level", int'(fifo_level), 0);
      chk("t6_issued", int'(issued_cnt), 0);
      chk("t6_seq_done", int'(seq_done), 0);
      model_reset();
      tick();
      reset = 1'b1;
      log_cmd.delete(); log_cyc.delete();
      push1(7);
      wait_log("t6_reissue", 1, 30);
      if (log_cmd.size() >= 1) chk("t6_cmd_after", log_cmd[0], 7);

      // Random traffic
      do_reset();
      bmode = 2;
      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         in_cmd   = 4'($urandom_range(0, 15));
         done     = ($urandom_range(0, 79) == 0);
         flush    = ($urandom_range(0, 49) == 0);
         tick();
      end
      in_valid = 1'b0; done = 1'b0; flush = 1'b0;
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
